// File: rtl/fb_arb_pkg.sv
// Shared types and constants for the VGA framebuffer arbiter slice.
package fb_arb_pkg;

  typedef enum logic [1:0] {
    S_FLUSH = 2'd0,
    S_FILL  = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  typedef logic [7:0] rgb332_t;

  function automatic int unsigned fb_last_addr(input int unsigned h_res,
                                               input int unsigned v_res);
    return h_res * v_res - 1;
  endfunction

  localparam int unsigned FB_LAST_ADDR = fb_last_addr(320, 240);

endpackage

// File: rtl/fb_prefetch_fifo.sv
// Scanout prefetch FIFO: push/pop/flush, occupancy count, head pixel (0 when empty).
module fb_prefetch_fifo
  import fb_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             wdata,
  output logic [7:0]             rdata,
  output logic [$clog2(DEPTH):0] occ
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = AW + 1;

  rgb332_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          empty;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (occ == '0);
  assign push_ok = push && !flush;
  assign pop_ok  = pop && !flush && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to 0 whenever occ is 0.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: VGA scanout prefetch vs. game writer.
// FB_VBLANK_WRITE_EN adds i_VBLANK and restricts write grants to vertical blanking.
module vga_fb_arbiter
  import fb_arb_pkg::*;
#(
  parameter int unsigned H_RES      = 320,
  parameter int unsigned V_RES      = 240,
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LOW_WATER  = 2,
  parameter int unsigned WAIT_MAX   = 8
) (
  input  logic              i_CLK,
  input  logic              i_RESET_n,
  input  logic              i_FRAME_START,
  input  logic              i_PIX_POP,
  output logic [7:0]        o_PIX_RGB,
  output logic              o_PIX_VALID,
  output logic              o_UNDERFLOW,
  input  logic              i_WR_REQ,
  input  logic [ADDR_W-1:0] i_WR_ADDR,
  input  logic [7:0]        i_WR_DATA,
  output logic              o_WR_ACK,
  output logic [ADDR_W-1:0] o_MEM_ADDR,
  output logic              o_MEM_WE,
  output logic [7:0]        o_MEM_WDATA,
`ifdef FB_VBLANK_WRITE_EN
  input  logic              i_VBLANK,
`endif
  input  logic [7:0]        i_MEM_RDATA
);

  localparam int unsigned          OCC_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned          WAIT_W    = $clog2(WAIT_MAX + 1);
  localparam logic [ADDR_W-1:0]    LAST_ADDR = ADDR_W'(fb_last_addr(H_RES, V_RES));

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] rd_ptr;
  logic              inflight;
  logic [WAIT_W-1:0] wait_cnt;
  logic [OCC_W-1:0]  occ;
  logic              wr_allowed;
  logic              credit;
  logic              rd_en;
  logic              starved;
  logic              wr_grant;
  logic              rd_issue;
  logic              push;
  logic              flush;
  logic              pop_req;

`ifdef FB_VBLANK_WRITE_EN
  assign wr_allowed = i_VBLANK;
`else
  assign wr_allowed = 1'b1;
`endif

  always_comb begin
    credit   = (32'(occ) + 32'(inflight)) < FIFO_DEPTH;
    // A frame restart suppresses reads in its own cycle so nothing is issued at a stale pointer.
    rd_en    = (state != S_FLUSH) && !i_FRAME_START && credit;
    starved  = (wait_cnt >= WAIT_W'(WAIT_MAX)) && (32'(occ) >= LOW_WATER);
    wr_grant = i_WR_REQ && wr_allowed && (!rd_en || starved);
    rd_issue = rd_en && !wr_grant;
    flush    = (state == S_FLUSH) || i_FRAME_START;
    push     = inflight && !flush;
    pop_req  = i_PIX_POP && !i_FRAME_START;
  end

  always_comb begin
    o_WR_ACK    = wr_grant;
    o_MEM_WE    = wr_grant;
    o_MEM_WDATA = wr_grant ? i_WR_DATA : '0;
    o_MEM_ADDR  = wr_grant ? i_WR_ADDR : (rd_issue ? rd_ptr : '0);
    o_UNDERFLOW = pop_req && !o_PIX_VALID;
  end

  assign o_PIX_VALID = (occ != '0);

  fb_prefetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_CLK),
    .rst_n (i_RESET_n),
    .flush (flush),
    .push  (push),
    .pop   (pop_req),
    .wdata (i_MEM_RDATA),
    .rdata (o_PIX_RGB),
    .occ   (occ)
  );

  always_comb begin
    state_nxt = state;
    if (i_FRAME_START) begin
      state_nxt = S_FLUSH;
    end else begin
      case (state)
        S_FLUSH: if (!inflight) state_nxt = S_FILL;
        S_FILL:  if (occ == OCC_W'(FIFO_DEPTH)) state_nxt = S_RUN;
        S_RUN:   state_nxt = S_RUN;
        default: state_nxt = S_FLUSH;
      endcase
    end
  end

  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      state    <= S_FLUSH;
      rd_ptr   <= '0;
      inflight <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= rd_issue;
      if (flush)
        rd_ptr <= '0;
      else if (rd_issue)
        rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + ADDR_W'(1);
      if (!i_WR_REQ || wr_grant)
        wait_cnt <= '0;
      else if (wr_allowed && (wait_cnt < WAIT_W'(WAIT_MAX)))
        wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

endmodule
